// File: rtl/mem_wb_if.sv
// Handshake and register-file write-port bundle between the ALU stage and mem_wb_stage.
interface mem_wb_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ir;
  logic [31:0] ID;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] alu_rd;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        done;

  modport master (
    output in_valid, ir, ID, rs, rt, alu_rd,
    input  in_ready, wb_en, wb_addr, wb_data, done
  );

  modport slave (
    input  in_valid, ir, ID, rs, rt, alu_rd,
    output in_ready, wb_en, wb_addr, wb_data, done
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: one instruction in flight, lw/sw against a local
// word-addressed data memory, single register-file write port.
module mem_wb_stage #(
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] ITYPE_MASK = 32'h0000_2404,
  parameter logic [31:0] NOWB_MASK  = 32'h00FF_C001
) (
  input  logic     clk,
  input  logic     reset,
  mem_wb_if.slave  bus
);
  localparam int         AW    = $clog2(DMEM_DEPTH);
  localparam logic [4:0] ID_LW = 5'd13;
  localparam logic [4:0] ID_SW = 5'd14;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB} state_t;

  typedef struct packed {
    logic [20:0] ir;
    logic [4:0]  id;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] alu;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] ld_q, ld_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] dmem_q [DMEM_DEPTH];

  logic [31:0]   ea;
  logic [AW-1:0] widx;
  logic [4:0]    dest;
  logic          is_lw, is_sw, accept;
  logic          mem_we, ld_en, wb_fire, done_c;
  logic          unused_bits;

  assign unused_bits = ^{bus.ID[31:5], bus.ir[31:21], ea[31:AW]};

  always_comb begin
    ea      = req_q.rs + {{16{req_q.ir[15]}}, req_q.ir[15:0]};
    widx    = ea[AW-1:0];
    dest    = ITYPE_MASK[req_q.id] ? req_q.ir[20:16] : req_q.ir[15:11];
    is_lw   = (req_q.id == ID_LW);
    is_sw   = (req_q.id == ID_SW);
    accept  = bus.in_valid && (state_q == S_IDLE);
    state_d = state_q;
    req_d   = req_q;
    mem_we  = 1'b0;
    ld_en   = 1'b0;
    wb_fire = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        req_d   = '{ir: bus.ir[20:0], id: bus.ID[4:0], rs: bus.rs, rt: bus.rt, alu: bus.alu_rd};
        state_d = (bus.ID[4:0] == ID_LW || bus.ID[4:0] == ID_SW) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (is_sw) begin
          mem_we  = 1'b1;
          done_c  = 1'b1;
          state_d = S_IDLE;
        end else begin
          ld_en   = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        done_c  = 1'b1;
        wb_fire = !NOWB_MASK[req_q.id] && (dest != 5'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // An instruction caught by reset must leave no trace: no store, no strobe, no retire.
    mem_we    = mem_we  & ~reset;
    wb_fire   = wb_fire & ~reset;
    done_c    = done_c  & ~reset;
    ld_d      = ld_en ? dmem_q[widx] : ld_q;
    wb_addr_d = wb_fire ? dest : wb_addr_q;
    wb_data_d = wb_fire ? (is_lw ? ld_q : req_q.alu) : wb_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_ff @(posedge clk) begin
    req_q <= req_d;
    ld_q  <= ld_d;
    if (mem_we) dmem_q[widx] <= req_q.rt;
  end

  assign bus.in_ready = (state_q == S_IDLE);
  assign bus.wb_en    = wb_fire;
  assign bus.wb_addr  = wb_addr_d;
  assign bus.wb_data  = wb_data_d;
  assign bus.done     = done_c;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: scoreboard of retirements plus per-scenario timing checks.
module tb_mem_wb_stage;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_wb_if bus();

  mem_wb_stage #(.DMEM_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;

  function automatic logic [31:0] mk_ir(input logic [4:0] rtf, input logic [15:0] imm);
    return {6'd0, 5'd0, rtf, imm};
  endfunction

  function automatic logic [15:0] rdf(input logic [4:0] rd);
    return {rd, 11'd0};
  endfunction

  // Expected retirement; non-writing ops expect the held address/data.
  function automatic void push_exp(input logic en, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    if (en) begin
      m_addr = a;
      m_data = d;
    end
    e.en = en; e.addr = m_addr; e.data = m_data;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected_done: got wb_en=%0b addr=%0d data=%h, none expected",
                   bus.wb_en, bus.wb_addr, bus.wb_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus.wb_en !== e.en || bus.wb_addr !== e.addr || bus.wb_data !== e.data) begin
            miscompares++;
            $display("FAIL sb_retire: got en=%0b addr=%0d data=%h, want en=%0b addr=%0d data=%h",
                     bus.wb_en, bus.wb_addr, bus.wb_data, e.en, e.addr, e.data);
          end
        end
      end else if (bus.wb_en) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_wb_without_done: wb_en=1 done=0");
      end
    end
  end

  // Waits for in_ready, presents one instruction, returns at the negedge of cycle N+1.
  task automatic send(input logic [31:0] ir, input logic [31:0] id, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [31:0] alu);
    int t = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (bus.in_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, t);
    end
    bus.in_valid = 1'b1;
    bus.ir = ir; bus.ID = id; bus.rs = rs; bus.rt = rt; bus.alu_rd = alu;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 5;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    if (bus.wb_en !== 1'b0)    begin miscompares++; $display("FAIL rst_wb_en: got %b want 0", bus.wb_en); end
    if (bus.wb_addr !== 5'd0)  begin miscompares++; $display("FAIL rst_wb_addr: got %0d want 0", bus.wb_addr); end
    if (bus.wb_data !== 32'd0) begin miscompares++; $display("FAIL rst_wb_data: got %h want 0", bus.wb_data); end
    if (bus.done !== 1'b0)     begin miscompares++; $display("FAIL rst_done: got %b want 0", bus.done); end
    reset = 1'b0;
    m_addr = 5'd0;
    m_data = 32'd0;
  endtask

  task automatic test_alu;
    logic [31:0] r;
    push_exp(1'b1, 5'd1, 32'd22);
    send(mk_ir(5'd0, rdf(5'd1)), 32'd1, 32'd0, 32'd0, 32'd22);
    vectors++;
    if (bus.done !== 1'b1 || bus.wb_en !== 1'b1) begin
      miscompares++; $display("FAIL add_latency: got done=%b wb_en=%b want 1/1", bus.done, bus.wb_en);
    end
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.done !== 1'b0) begin
      miscompares++; $display("FAIL add_return: got ready=%b done=%b want 1/0", bus.in_ready, bus.done);
    end
    // I-type: rt field 1 must win over rd field 5
    push_exp(1'b1, 5'd1, 32'd109);
    send(mk_ir(5'd1, rdf(5'd5)), 32'd10, 32'd0, 32'd0, 32'd109);
    r = $urandom;
    push_exp(1'b1, 5'd31, r);
    send(mk_ir(5'd3, rdf(5'd31)), 32'd3, 32'd0, 32'd0, r);
  endtask

  task automatic test_sw_lw;
    push_exp(1'b0, 5'd0, 32'd0);
    send(mk_ir(5'd0, 16'd100), 32'd14, 32'd10, 32'hDEADBEEF, 32'd0);
    vectors++;
    if (bus.done !== 1'b1 || bus.wb_en !== 1'b0) begin
      miscompares++; $display("FAIL sw_latency: got done=%b wb_en=%b want 1/0", bus.done, bus.wb_en);
    end
    push_exp(1'b1, 5'd4, 32'hDEADBEEF);
    send(mk_ir(5'd4, 16'd100), 32'd13, 32'd10, 32'd0, 32'd0);
    vectors++;
    if (bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL lw_n1: got done=%b ready=%b want 0/0", bus.done, bus.in_ready);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b1 || bus.wb_en !== 1'b1) begin
      miscompares++; $display("FAIL lw_n2: got done=%b wb_en=%b want 1/1", bus.done, bus.wb_en);
    end
    // negative offset: 200 - 50 and 100 + 50 both hit word 150
    push_exp(1'b0, 5'd0, 32'd0);
    send(mk_ir(5'd0, 16'hFFCE), 32'd14, 32'd200, 32'hCAFEF00D, 32'd0);
    push_exp(1'b1, 5'd6, 32'hCAFEF00D);
    send(mk_ir(5'd6, 16'd50), 32'd13, 32'd100, 32'd0, 32'd0);
  endtask

  task automatic test_jump_wrap;
    push_exp(1'b0, 5'd0, 32'd0);
    send(mk_ir(5'd2, rdf(5'd7)), 32'd21, 32'd0, 32'd0, 32'd1234);
    vectors++;
    if (bus.done !== 1'b1 || bus.wb_en !== 1'b0) begin
      miscompares++; $display("FAIL j_done: got done=%b wb_en=%b want 1/0", bus.done, bus.wb_en);
    end
    push_exp(1'b0, 5'd0, 32'd0);
    send(mk_ir(5'd0, 16'd3), 32'd14, DEPTH, 32'h12345678, 32'd0);
    push_exp(1'b1, 5'd9, 32'h12345678);
    send(mk_ir(5'd9, 16'd3), 32'd13, 32'd0, 32'd0, 32'd0);
    push_exp(1'b1, 5'd10, 32'h12345678);
    send(mk_ir(5'd10, 16'd0), 32'd13, 2 * DEPTH + 3, 32'd0, 32'd0);
    // 32-bit address overflow: 0xFFFFFFFF + 5 = 4
    push_exp(1'b0, 5'd0, 32'd0);
    send(mk_ir(5'd0, 16'd5), 32'd14, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'd0);
    push_exp(1'b1, 5'd11, 32'h0F0F_0F0F);
    send(mk_ir(5'd11, 16'hFFFF), 32'd13, 32'd5, 32'd0, 32'd0);
  endtask

  task automatic test_zero_reg;
    push_exp(1'b0, 5'd0, 32'd0);
    send(mk_ir(5'd0, rdf(5'd0)), 32'd1, 32'd0, 32'd0, 32'd55);
    vectors++;
    if (bus.done !== 1'b1 || bus.wb_en !== 1'b0) begin
      miscompares++; $display("FAIL r0_drop: got done=%b wb_en=%b want 1/0", bus.done, bus.wb_en);
    end
    push_exp(1'b0, 5'd0, 32'd0);
    send(mk_ir(5'd3, rdf(5'd3)), 32'd0, 32'd0, 32'd0, 32'd66);
    push_exp(1'b0, 5'd0, 32'd0);
    send(mk_ir(5'd0, 16'd100), 32'd13, 32'd10, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b1 || bus.wb_en !== 1'b0) begin
      miscompares++; $display("FAIL lw_r0: got done=%b wb_en=%b want 1/0", bus.done, bus.wb_en);
    end
  endtask

  task automatic test_back_to_back;
    int accepts = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ir = mk_ir(5'd0, rdf(5'd2)); bus.ID = 32'd1; bus.rs = 0; bus.rt = 0; bus.alu_rd = 32'd77;
    for (int i = 0; i < 5; i++) begin
      if (bus.in_ready === 1'b1) begin
        accepts++;
        push_exp(1'b1, 5'd2, 32'd77);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (accepts != 3) begin
      miscompares++; $display("FAIL backpressure_accepts: got %0d want 3", accepts);
    end
  endtask

  task automatic test_reset_midop;
    push_exp(1'b0, 5'd0, 32'd0);
    send(mk_ir(5'd0, 16'd0), 32'd14, 32'd7, 32'hA5A5A5A5, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ir = mk_ir(5'd0, 16'd0); bus.ID = 32'd14; bus.rs = 32'd7; bus.rt = 32'h0BADF00D;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.wb_en !== 1'b0) begin
      miscompares++; $display("FAIL midrst_mem: got done=%b wb_en=%b want 0/0", bus.done, bus.wb_en);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_addr = 5'd0;
    m_data = 32'd0;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.done !== 1'b0 || bus.wb_en !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_after: got ready=%b done=%b wb_en=%b want 1/0/0", bus.in_ready, bus.done, bus.wb_en);
    end
    push_exp(1'b1, 5'd3, 32'hA5A5A5A5);
    send(mk_ir(5'd3, 16'd0), 32'd13, 32'd7, 32'd0, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.ir = 0; bus.ID = 0; bus.rs = 0; bus.rt = 0; bus.alu_rd = 0;
    test_reset();
    test_alu();
    test_sw_lw();
    test_jump_wrap();
    test_zero_reg();
    test_back_to_back();
    test_reset_midop();
    repeat (3) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++; $display("FAIL sb_leftover: got %0d pending retirements want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
